// File: rtl/fight_referee_if.sv
// Bus between the match referee and the game: player states and boxes in, match status out.
interface fight_referee_if;
   logic        start;
   logic [3:0]  p1_state;
   logic [3:0]  p2_state;
   logic [39:0] p1_basic_box;
   logic [39:0] p1_dir_box;
   logic [39:0] p1_hurt_box;
   logic [39:0] p2_basic_box;
   logic [39:0] p2_dir_box;
   logic [39:0] p2_hurt_box;
   logic [2:0]  gamestate;
   logic [1:0]  p1_hit_flag;
   logic [1:0]  p2_hit_flag;
   logic [2:0]  p1_health;
   logic [2:0]  p2_health;
   logic [2:0]  p1_block;
   logic [2:0]  p2_block;
   logic [1:0]  winner;

   modport master (
      output start, p1_state, p2_state,
             p1_basic_box, p1_dir_box, p1_hurt_box,
             p2_basic_box, p2_dir_box, p2_hurt_box,
      input  gamestate, p1_hit_flag, p2_hit_flag,
             p1_health, p2_health, p1_block, p2_block, winner
   );

   modport slave (
      input  start, p1_state, p2_state,
             p1_basic_box, p1_dir_box, p1_hurt_box,
             p2_basic_box, p2_dir_box, p2_hurt_box,
      output gamestate, p1_hit_flag, p2_hit_flag,
             p1_health, p2_health, p1_block, p2_block, winner
   );
endinterface

// File: rtl/fight_referee.sv
// Match referee: sequences menu/countdown/fight/round-over, resolves hitbox overlaps,
// owns health and block counters for both players and declares the winner.
module fight_referee #(
   parameter int unsigned MAX_HEALTH       = 5,
   parameter int unsigned MAX_BLOCK        = 3,
   parameter int unsigned BLOCK_REGEN      = 120,
   parameter int unsigned COUNTDOWN_CYCLES = 180,
   parameter int unsigned ROUND_CYCLES     = 5400,
   parameter int unsigned END_CYCLES       = 240
) (
   input  logic           clk,
   input  logic           rst,
   fight_referee_if.slave bus
);
   localparam int unsigned TIMER_W = 16;
   localparam int unsigned REGEN_W = 8;
   localparam int unsigned CNT_W   = 3;

   localparam logic [2:0] S_MENU       = 3'd0;
   localparam logic [2:0] S_COUNTDOWN  = 3'd1;
   localparam logic [2:0] S_FIGHT      = 3'd2;
   localparam logic [2:0] S_ROUND_OVER = 3'd3;

   localparam logic [3:0] ST_BACK      = 4'd2;
   localparam logic [3:0] ST_BASIC_END = 4'd4;
   localparam logic [3:0] ST_DIR_END   = 4'd7;
   localparam logic [3:0] ST_HITSTUN   = 4'd9;
   localparam logic [3:0] ST_BLOCKSTUN = 4'd10;

   localparam logic [CNT_W-1:0] HP_FULL  = CNT_W'(MAX_HEALTH);
   localparam logic [CNT_W-1:0] BLK_FULL = CNT_W'(MAX_BLOCK);

   // Boxes are {x1,x2,y1,y2}; inclusive unsigned interval overlap on both axes.
   function automatic logic overlap(input logic [39:0] a, input logic [39:0] b);
      return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
             (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
   endfunction

   function automatic logic [1:0] hit_kind(input logic [3:0]  att_st,
                                           input logic [39:0] att_basic,
                                           input logic [39:0] att_dir,
                                           input logic        att_lock,
                                           input logic [3:0]  def_st,
                                           input logic [39:0] def_hurt);
      logic [1:0] kind;
      kind = 2'b00;
      if (!att_lock && def_st != ST_HITSTUN && def_st != ST_BLOCKSTUN) begin
         if (att_st == ST_BASIC_END && overlap(att_basic, def_hurt))
            kind = 2'b01;
         else if (att_st == ST_DIR_END && overlap(att_dir, def_hurt))
            kind = 2'b10;
      end
      return kind;
   endfunction

   // Lock survives only while the attacker stays in an active (end) frame.
   function automatic logic next_lock(input logic lock, input logic [3:0] att_st,
                                      input logic issued);
      return issued || (lock && (att_st == ST_BASIC_END || att_st == ST_DIR_END));
   endfunction

   function automatic logic [CNT_W-1:0] next_block(input logic [CNT_W-1:0] blk,
                                                   input logic dec, input logic regen);
      logic [CNT_W-1:0] nb;
      nb = blk;
      if (dec && !regen && blk != '0)
         nb = blk - CNT_W'(1);
      else if (regen && !dec && blk < BLK_FULL)
         nb = blk + CNT_W'(1);
      return nb;
   endfunction

   function automatic logic [CNT_W-1:0] next_health(input logic [CNT_W-1:0] hp,
                                                    input logic take);
      return (take && hp != '0) ? hp - CNT_W'(1) : hp;
   endfunction

   logic [2:0]         gs_q, gs_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [REGEN_W-1:0] regen_q, regen_d;
   logic [CNT_W-1:0]   p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
   logic [CNT_W-1:0]   p1_blk_q, p1_blk_d, p2_blk_q, p2_blk_d;
   logic               p1_lock_q, p1_lock_d, p2_lock_q, p2_lock_d;
   logic               p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
   logic [1:0]         p1_flag_q, p1_flag_d, p2_flag_q, p2_flag_d;
   logic [1:0]         winner_q, winner_d;

   logic               in_fight, regen_fire, p1_blocked, p2_blocked;
   logic [1:0]         p1_hit, p2_hit;

   // Hits taken this cycle; pX_hit is the hit landed on player X.
   always_comb begin
      in_fight   = (gs_q == S_FIGHT);
      regen_fire = in_fight && (regen_q == REGEN_W'(BLOCK_REGEN - 1));
      p1_hit     = 2'b00;
      p2_hit     = 2'b00;
      if (in_fight) begin
         p1_hit = hit_kind(bus.p2_state, bus.p2_basic_box, bus.p2_dir_box, p2_lock_q,
                           bus.p1_state, bus.p1_hurt_box);
         p2_hit = hit_kind(bus.p1_state, bus.p1_basic_box, bus.p1_dir_box, p1_lock_q,
                           bus.p2_state, bus.p2_hurt_box);
      end
      p1_blocked = (p1_hit != 2'b00) && (bus.p1_state == ST_BACK) && (p1_blk_q != '0);
      p2_blocked = (p2_hit != 2'b00) && (bus.p2_state == ST_BACK) && (p2_blk_q != '0);
   end

   // Next-state and counter updates; block charge is spent one edge late.
   always_comb begin
      gs_d      = gs_q;
      timer_d   = timer_q;
      regen_d   = regen_q;
      winner_d  = winner_q;
      p1_flag_d = p1_hit;
      p2_flag_d = p2_hit;
      p1_pend_d = p1_blocked;
      p2_pend_d = p2_blocked;
      p1_hp_d   = next_health(p1_hp_q, (p1_hit != 2'b00) && !p1_blocked);
      p2_hp_d   = next_health(p2_hp_q, (p2_hit != 2'b00) && !p2_blocked);
      p1_blk_d  = next_block(p1_blk_q, p1_pend_q, regen_fire);
      p2_blk_d  = next_block(p2_blk_q, p2_pend_q, regen_fire);
      p1_lock_d = next_lock(p1_lock_q, bus.p1_state, p2_hit != 2'b00);
      p2_lock_d = next_lock(p2_lock_q, bus.p2_state, p1_hit != 2'b00);

      case (gs_q)
         S_MENU: begin
            if (bus.start) begin
               gs_d      = S_COUNTDOWN;
               timer_d   = '0;
               regen_d   = '0;
               winner_d  = 2'd0;
               p1_hp_d   = HP_FULL;
               p2_hp_d   = HP_FULL;
               p1_blk_d  = BLK_FULL;
               p2_blk_d  = BLK_FULL;
               p1_lock_d = 1'b0;
               p2_lock_d = 1'b0;
               p1_pend_d = 1'b0;
               p2_pend_d = 1'b0;
            end
         end
         S_COUNTDOWN: begin
            if (timer_q == TIMER_W'(COUNTDOWN_CYCLES - 1)) begin
               gs_d    = S_FIGHT;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_FIGHT: begin
            regen_d = regen_fire ? '0 : regen_q + REGEN_W'(1);
            // KO and timeout share one rule: higher remaining health wins, tie is a draw.
            if (p1_hp_d == '0 || p2_hp_d == '0 || timer_q == TIMER_W'(ROUND_CYCLES - 1)) begin
               gs_d    = S_ROUND_OVER;
               timer_d = '0;
               if (p1_hp_d > p2_hp_d)      winner_d = 2'd1;
               else if (p2_hp_d > p1_hp_d) winner_d = 2'd2;
               else                        winner_d = 2'd3;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         S_ROUND_OVER: begin
            if (timer_q == TIMER_W'(END_CYCLES - 1)) begin
               gs_d    = S_MENU;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: begin
            gs_d    = S_MENU;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gs_q      <= S_MENU;
         timer_q   <= '0;
         regen_q   <= '0;
         winner_q  <= 2'd0;
         p1_hp_q   <= HP_FULL;
         p2_hp_q   <= HP_FULL;
         p1_blk_q  <= BLK_FULL;
         p2_blk_q  <= BLK_FULL;
         p1_lock_q <= 1'b0;
         p2_lock_q <= 1'b0;
         p1_pend_q <= 1'b0;
         p2_pend_q <= 1'b0;
         p1_flag_q <= 2'b00;
         p2_flag_q <= 2'b00;
      end else begin
         gs_q      <= gs_d;
         timer_q   <= timer_d;
         regen_q   <= regen_d;
         winner_q  <= winner_d;
         p1_hp_q   <= p1_hp_d;
         p2_hp_q   <= p2_hp_d;
         p1_blk_q  <= p1_blk_d;
         p2_blk_q  <= p2_blk_d;
         p1_lock_q <= p1_lock_d;
         p2_lock_q <= p2_lock_d;
         p1_pend_q <= p1_pend_d;
         p2_pend_q <= p2_pend_d;
         p1_flag_q <= p1_flag_d;
         p2_flag_q <= p2_flag_d;
      end
   end

   assign bus.gamestate   = gs_q;
   assign bus.p1_hit_flag = p1_flag_q;
   assign bus.p2_hit_flag = p2_flag_q;
   assign bus.p1_health   = p1_hp_q;
   assign bus.p2_health   = p2_hp_q;
   assign bus.p1_block    = p1_blk_q;
   assign bus.p2_block    = p2_blk_q;
   assign bus.winner      = winner_q;
endmodule

// File: tb/tb_fight_referee.sv
// Bench for fight_referee: directed match scenarios plus randomized rounds, all checked
// every cycle against a frame-level model of the match rules.
module tb_fight_referee;
   localparam int MAXH = 5, MAXB = 3, REGEN = 120, CD = 180, RC = 5400, EC = 240;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fight_referee_if bus();
   fight_referee dut (.clk(clk), .rst(rst), .bus(bus));

   int n_pass = 0, n_total = 0, cyc = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Model state: phase number, frames spent in phase, per-player arrays (0 = p1, 1 = p2).
   int m_gs, m_elapsed, m_winner;
   int m_health[2], m_block[2], m_flag[2];
   bit m_lock[2], m_pend[2];

   function automatic bit ov(input logic [39:0] a, input logic [39:0] b);
      int ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
      ax1 = int'(a[39:30]); ax2 = int'(a[29:20]); ay1 = int'(a[19:10]); ay2 = int'(a[9:0]);
      bx1 = int'(b[39:30]); bx2 = int'(b[29:20]); by1 = int'(b[19:10]); by2 = int'(b[9:0]);
      return ax1 <= bx2 && bx1 <= ax2 && ay1 <= by2 && by1 <= ay2;
   endfunction

   task automatic model_reload();
      for (int p = 0; p < 2; p++) begin
         m_health[p] = MAXH; m_block[p] = MAXB; m_lock[p] = 0; m_pend[p] = 0;
      end
      m_winner = 0;
   endtask

   task automatic model_step();
      int st[2], kind[2], nh[2], nb[2];
      logic [39:0] bas[2], dir[2], hurt[2];
      bit blk[2], nl[2], regen;
      if (rst) begin
         model_reload();
         m_gs = 0; m_elapsed = 0; m_flag[0] = 0; m_flag[1] = 0;
         return;
      end
      st[0] = int'(bus.p1_state); st[1] = int'(bus.p2_state);
      bas[0] = bus.p1_basic_box; bas[1] = bus.p2_basic_box;
      dir[0] = bus.p1_dir_box;   dir[1] = bus.p2_dir_box;
      hurt[0] = bus.p1_hurt_box; hurt[1] = bus.p2_hurt_box;
      regen = (m_gs == 2) && ((m_elapsed + 1) % REGEN == 0);
      for (int d = 0; d < 2; d++) begin
         int a = 1 - d;
         kind[d] = 0;
         if (m_gs == 2 && !m_lock[a] && st[d] != 9 && st[d] != 10) begin
            if (st[a] == 4 && ov(bas[a], hurt[d]))      kind[d] = 1;
            else if (st[a] == 7 && ov(dir[a], hurt[d])) kind[d] = 2;
         end
      end
      for (int d = 0; d < 2; d++) begin
         int a = 1 - d;
         blk[d] = kind[d] != 0 && st[d] == 2 && m_block[d] > 0;
         nh[d] = (kind[d] != 0 && !blk[d] && m_health[d] > 0) ? m_health[d] - 1 : m_health[d];
         nb[d] = m_block[d];
         if (m_pend[d] && !regen && nb[d] > 0) nb[d] = nb[d] - 1;
         else if (regen && !m_pend[d] && nb[d] < MAXB) nb[d] = nb[d] + 1;
         nl[a] = kind[d] != 0 || (m_lock[a] && (st[a] == 4 || st[a] == 7));
      end
      for (int p = 0; p < 2; p++) begin
         m_flag[p] = kind[p]; m_health[p] = nh[p]; m_block[p] = nb[p];
         m_pend[p] = blk[p];  m_lock[p] = nl[p];
      end
      case (m_gs)
         0: if (bus.start) begin m_gs = 1; m_elapsed = 0; model_reload(); end
         1: begin
            m_elapsed++;
            if (m_elapsed == CD) begin m_gs = 2; m_elapsed = 0; end
         end
         2: begin
            m_elapsed++;
            if (nh[0] == 0 || nh[1] == 0 || m_elapsed == RC) begin
               m_gs = 3; m_elapsed = 0;
               m_winner = (nh[0] > nh[1]) ? 1 : (nh[1] > nh[0]) ? 2 : 3;
            end
         end
         default: begin
            m_elapsed++;
            if (m_elapsed == EC) begin m_gs = 0; m_elapsed = 0; end
         end
      endcase
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (chk_en) begin
         check("gamestate", int'(bus.gamestate), m_gs);
         check("p1_hit_flag", int'(bus.p1_hit_flag), m_flag[0]);
         check("p2_hit_flag", int'(bus.p2_hit_flag), m_flag[1]);
         check("p1_health", int'(bus.p1_health), m_health[0]);
         check("p2_health", int'(bus.p2_health), m_health[1]);
         check("p1_block", int'(bus.p1_block), m_block[0]);
         check("p2_block", int'(bus.p2_block), m_block[1]);
         check("winner", int'(bus.winner), m_winner);
      end
   end

   task automatic wait_gs(input int target, input int limit);
      int n = 0;
      while (int'(bus.gamestate) != target && n < limit) begin tick(); n++; end
      check("wait_gamestate", int'(bus.gamestate), target);
   endtask

   function automatic logic [39:0] rand_box();
      int x1, y1, x2, y2;
      x1 = $urandom_range(0, 300); y1 = $urandom_range(0, 300);
      x2 = x1 + $urandom_range(0, 150); y2 = y1 + $urandom_range(0, 150);
      return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
   endfunction

   int hold[2];
   task automatic rand_player(input int p, input int aggr);
      int s;
      if (hold[p] > 0) begin hold[p]--; return; end
      hold[p] = $urandom_range(0, 2);
      if ($urandom_range(0, 999) < aggr) s = $urandom_range(3, 10);
      else s = $urandom_range(0, 2);
      if (p == 0) begin
         bus.p1_state = 4'(s); bus.p1_basic_box = rand_box();
         bus.p1_dir_box = rand_box(); bus.p1_hurt_box = rand_box();
      end else begin
         bus.p2_state = 4'(s); bus.p2_basic_box = rand_box();
         bus.p2_dir_box = rand_box(); bus.p2_hurt_box = rand_box();
      end
   endtask

   initial begin
      int t0, aggr, rst_at, k;
      bit seen_over;
      rst = 1'b1; bus.start = 1'b0;
      bus.p1_state = 4'd0; bus.p2_state = 4'd0;
      bus.p1_basic_box = {10'd100, 10'd140, 10'd0, 10'd50};
      bus.p1_dir_box   = {10'd100, 10'd140, 10'd0, 10'd50};
      bus.p1_hurt_box  = {10'd100, 10'd160, 10'd0, 10'd60};
      bus.p2_basic_box = {10'd150, 10'd180, 10'd20, 10'd40};
      bus.p2_dir_box   = {10'd150, 10'd180, 10'd20, 10'd40};
      bus.p2_hurt_box  = {10'd140, 10'd200, 10'd10, 10'd60};
      tick(); tick();
      chk_en = 1'b1;
      check("reset_gamestate", int'(bus.gamestate), 0);
      check("reset_health", int'(bus.p1_health) + int'(bus.p2_health), 10);
      check("reset_block", int'(bus.p1_block) * 8 + int'(bus.p2_block), 27);
      check("reset_winner", int'(bus.winner), 0);

      // Round 1: sequencing, basic hit with touching edges, lock, block, stun, timeout.
      rst = 1'b0; bus.start = 1'b1; tick();
      check("menu_to_countdown", int'(bus.gamestate), 1);
      bus.start = 1'b0; t0 = cyc;
      wait_gs(2, 1000);
      check("countdown_len", cyc - t0, CD);
      t0 = cyc;
      bus.p1_state = 4'd4; tick();
      check("basic_flag", int'(bus.p2_hit_flag), 1);
      check("basic_health", int'(bus.p2_health), 4);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lock_no_rehit", int'(bus.p2_hit_flag), 0);
      end
      check("lock_health", int'(bus.p2_health), 4);
      bus.p1_state = 4'd0; tick();
      bus.p1_dir_box = {10'd100, 10'd139, 10'd0, 10'd50};
      bus.p1_state = 4'd7; tick();
      check("dir_miss_by_one", int'(bus.p2_hit_flag), 0);
      bus.p1_state = 4'd0; bus.p1_dir_box = {10'd100, 10'd140, 10'd0, 10'd50}; tick();
      bus.p2_state = 4'd2; bus.p1_state = 4'd7; tick();
      check("block_flag", int'(bus.p2_hit_flag), 2);
      check("block_health", int'(bus.p2_health), 4);
      check("block_visible", int'(bus.p2_block), 3);
      bus.p1_state = 4'd0; tick();
      check("block_spent", int'(bus.p2_block), 2);
      bus.p2_state = 4'd0; bus.p1_state = 4'd7; tick();
      check("rehit_health", int'(bus.p2_health), 3);
      bus.p1_state = 4'd0; tick();
      bus.p2_state = 4'd9; bus.p1_state = 4'd4; tick();
      check("stun_no_flag", int'(bus.p2_hit_flag), 0);
      check("stun_health", int'(bus.p2_health), 3);
      bus.p1_state = 4'd0; bus.p2_state = 4'd0;
      wait_gs(3, RC + 100);
      check("fight_len", cyc - t0, RC);
      check("timeout_winner", int'(bus.winner), 1);
      check("regen_saturated", int'(bus.p2_block), 3);
      t0 = cyc;
      wait_gs(0, EC + 100);
      check("roundover_len", cyc - t0, EC);

      // Round 2: idle timeout draw; start held high through ROUND_OVER.
      bus.start = 1'b1; tick();
      wait_gs(2, CD + 50);
      wait_gs(3, RC + 100);
      check("draw_winner", int'(bus.winner), 3);
      check("draw_health", int'(bus.p1_health) * 8 + int'(bus.p2_health), 45);
      t0 = cyc;
      wait_gs(0, EC + 100);
      check("start_ignored_len", cyc - t0, EC);
      tick();
      check("restart", int'(bus.gamestate), 1);
      bus.start = 1'b0;

      // Round 3: five trades end in a double KO.
      wait_gs(2, CD + 50);
      for (int i = 0; i < 5; i++) begin
         bus.p1_state = 4'd4; bus.p2_state = 4'd4; tick();
         if (i == 4) begin
            check("trade_flags", int'(bus.p1_hit_flag) * 4 + int'(bus.p2_hit_flag), 5);
            check("double_ko_health", int'(bus.p1_health) + int'(bus.p2_health), 0);
            check("double_ko_state", int'(bus.gamestate), 3);
            check("double_ko_winner", int'(bus.winner), 3);
         end
         bus.p1_state = 4'd0; bus.p2_state = 4'd0; tick();
      end
      wait_gs(0, EC + 100);

      // Randomized rounds: heavy, light and mid-round reset.
      for (int r = 0; r < 3; r++) begin
         aggr = (r == 0) ? 300 : (r == 1) ? 3 : 60;
         rst_at = (r == 2) ? 3000 : -1;
         seen_over = 1'b0; k = 0;
         hold[0] = 0; hold[1] = 0;
         while (k < 9000 && !(seen_over && bus.gamestate == 3'd0)) begin
            rand_player(0, aggr);
            rand_player(1, aggr);
            bus.start = ($urandom_range(0, 3) == 0);
            rst = (k == rst_at);
            tick(); k++;
            if (bus.gamestate == 3'd3) seen_over = 1'b1;
         end
      end
      rst = 1'b0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
